// File: rtl/swap_pkg.sv
// Shared definitions for the swap control FSM and the swap memory datapath.
package swap_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    // Phase encoding driven by the swap FSM on its sel output
    typedef enum logic [1:0] {
        PH_IDLE  = 2'b00,
        PH_LOAD  = 2'b01,
        PH_COPY  = 2'b10,
        PH_STORE = 2'b11
    } phase_t;

endpackage

// File: rtl/swap_regfile.sv
// Register-file memory: one write port, one registered read port and one
// combinational read port used by the swap phases.
module swap_regfile
    import swap_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic [ADDR_W-1:0] caddr,
    output logic [DATA_W-1:0] cdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Array write and registered read; the read sees the pre-write contents
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            rdata_r <= '0;
        end else begin
            if (we) begin
                mem_r[waddr] <= wdata;
            end
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;
    assign cdata = mem_r[caddr];

endmodule

// File: rtl/swap_mem_datapath.sv
// Datapath behind the swap FSM: exchanges mem[A] and mem[B] through a temp
// register, and serves host writes/reads plus busy, done and a swap counter.
module swap_mem_datapath
    import swap_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              swap,
    input  logic [1:0]        sel,
    input  logic              w,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              wr_drop,
    output logic [CNT_W-1:0]  swap_cnt
);

    phase_t            phase_s;
    logic [ADDR_W-1:0] lat_a_r;
    logic [ADDR_W-1:0] lat_b_r;
    logic [DATA_W-1:0] temp_r;
    logic              store_r;
    logic              done_r;
    logic              wr_drop_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [DATA_W-1:0] wdata_s;
    logic [ADDR_W-1:0] caddr_s;
    logic [DATA_W-1:0] cdata_s;

    assign phase_s = phase_t'(sel);
    // Only the load phase reads mem[lat_a]; copy needs mem[lat_b]
    assign caddr_s = (phase_s == PH_LOAD) ? lat_a_r : lat_b_r;

    // Write-port mux between host and swap phases
    always_comb begin
        we_s    = 1'b0;
        waddr_s = wr_addr;
        wdata_s = wr_data;
        case (phase_s)
            PH_IDLE: begin
                we_s = wr_en & ~w;
            end
            PH_COPY: begin
                we_s    = w;
                waddr_s = lat_a_r;
                wdata_s = cdata_s;
            end
            PH_STORE: begin
                we_s    = w;
                waddr_s = lat_b_r;
                wdata_s = temp_r;
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    swap_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .rstn  (rstn),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (wdata_s),
        .raddr (rd_addr),
        .rdata (rd_data),
        .caddr (caddr_s),
        .cdata (cdata_s)
    );

    // Swap address latch and temp capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_a_r <= '0;
            lat_b_r <= '0;
            temp_r  <= '0;
        end else begin
            if (phase_s == PH_IDLE && swap) begin
                lat_a_r <= addr_a;
                lat_b_r <= addr_b;
            end
            if (w && phase_s == PH_LOAD) begin
                temp_r <= cdata_s;
            end
        end
    end

    // Status pulses and saturating completed-swap counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            store_r   <= 1'b0;
            done_r    <= 1'b0;
            wr_drop_r <= 1'b0;
            cnt_r     <= '0;
        end else begin
            store_r   <= w && (phase_s == PH_STORE);
            done_r    <= store_r;
            wr_drop_r <= wr_en && w;
            if (w && phase_s == PH_STORE && cnt_r != {CNT_W{1'b1}}) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign busy     = w;
    assign done     = done_r;
    assign wr_drop  = wr_drop_r;
    assign swap_cnt = cnt_r;

endmodule

// File: doc/swap_mem_datapath.md
Name: swap_mem_datapath

Overview:
Datapath stage directly downstream of the swap control FSM. It consumes the FSM's 2-bit phase select `sel` and write-qualifier `w`, and owns a DEPTH x DATA_W register-file memory, a swap address pair latch and a temp register. It performs the three-step exchange mem[A]<->mem[B] through temp. It also gives the host a normal write port, a registered read port, busy/done status and a completed-swap counter.

Parameters:
DATA_W, 8, word width
DEPTH, 16, number of memory words
ADDR_W, 4, address width; must equal clog2(DEPTH)
CNT_W, 8, width of completed-swap counter

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset, asynchronous, active-low
swap  in  1  swap request; same signal that drives the FSM
sel  in  2  FSM phase: 00 idle, 01 load temp, 10 copy B->A, 11 write temp->B
w  in  1  FSM write qualifier; high in phases 01/10/11
addr_a  in  ADDR_W  first swap address, sampled on request
addr_b  in  ADDR_W  second swap address, sampled on request
wr_en  in  1  host write enable
wr_addr  in  ADDR_W  host write address
wr_data  in  DATA_W  host write data
rd_addr  in  ADDR_W  host read address
rd_data  out  DATA_W  registered read data
busy  out  1  swap in progress (combinational, = w)
done  out  1  one-cycle pulse after swap completes
wr_drop  out  1  one-cycle pulse: host write rejected
swap_cnt  out  CNT_W  completed swaps, saturating

Behaviour:
- Reset (async, rstn=0):
  - all memory words, temp, latched addresses, rd_data, done, wr_drop and swap_cnt go to 0.
  - A reset mid-swap abandons it: no partial writes after release, no done pulse.
- Address latch: on a clk edge with sel=00 and swap=1, lat_a<=addr_a and lat_b<=addr_b. The latch holds otherwise; address inputs are ignored during a swap.
- Phase actions (update only when w=1):
  - sel=01: temp <= mem[lat_a].
  - sel=10: mem[lat_a] <= mem[lat_b].
  - sel=11: mem[lat_b] <= temp; done<=1 next edge; swap_cnt<=swap_cnt+1, saturating at all-ones.
- sel!=00 with w=0 is illegal: no memory, temp or counter update.
- Host writes:
  - sel=00: mem[wr_addr] <= wr_data, including the same cycle as the swap request. The temp load in the following cycle therefore sees the new data.
  - w=1: write is discarded, wr_drop pulses for 1 cycle.
- Reads: rd_data <= mem[rd_addr] every edge, 1-cycle latency, regardless of busy. During a swap it returns the contents as of the previous edge (pre-write value).
- addr_a==addr_b: the swap runs all three phases, contents are unchanged, done and swap_cnt still update.
- Latency: swap request edge to done pulse = 4 clocks (phases 01, 10, 11 plus the done register). A back-to-back request is accepted only when sel returns to 00.
- done and wr_drop are single-cycle pulses, low otherwise.

Decomposition:
- Shared package `swap_pkg` holds:
  - phase constants PH_IDLE=2'b00, PH_LOAD=2'b01, PH_COPY=2'b10, PH_STORE=2'b11, shared with the FSM.
  - default DATA_W/DEPTH.
- One natural sub-module, `swap_regfile`: async-reset register array with one write port and one registered read port plus one combinational read port (for mem[lat_a]/mem[lat_b]). The write port is muxed between host and swap phases in the parent.

Test Plan:
- Reset: preload via host, pulse rstn low mid-sequence at sel=10 -> all words 0, rd_data=0, done never pulses, swap_cnt=0.
- Basic swap: mem[2]=0xAA, mem[5]=0x55, swap with addr_a=2, addr_b=5, FSM driven -> after done, rd mem[2]=0x55, mem[5]=0xAA; done high exactly 4 clocks after the request edge; swap_cnt=1.
- Write during busy: wr_en=1, wr_addr=2, wr_data=0x11 while sel=10 -> wr_drop pulses once, mem[2] ends 0x55 (swap result).
- Same-cycle write and request: wr_addr=2, wr_data=0x33 with swap=1 at sel=00, addr_a=2, addr_b=7 (mem[7]=0x44) -> final mem[2]=0x44, mem[7]=0x33.
- Self-swap: addr_a=addr_b=9, mem[9]=0x5A -> mem[9] stays 0x5A, done pulses, swap_cnt increments.
- Counter saturation: CNT_W=2, run 5 swaps -> swap_cnt reads 1,2,3,3,3.
